// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: character codes, FSM states and
// the pattern/length record produced by the character ROM.
package morse_pkg;

    localparam logic [5:0] CH_A     = 6'd0;
    localparam logic [5:0] CH_0     = 6'd26;
    localparam logic [5:0] CH_SPACE = 6'd36;
    localparam int         MAX_LEN  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_GAP,
        ST_ERR
    } state_t;

    // Pattern is LSB-first: bit 0 is the first element, 0 = dot, 1 = dash.
    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [2:0]         len;
    } morse_sym_t;

    function automatic morse_sym_t mk_sym(input logic [MAX_LEN-1:0] p, input logic [2:0] l);
        morse_sym_t s;
        s.pattern = p;
        s.len     = l;
        return s;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code to Morse pattern lookup (A-Z, 0-9, word space).
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] char_code,
    output morse_sym_t sym,
    output logic       is_space,
    output logic       valid
);

    always_comb begin
        sym      = mk_sym(5'b00000, 3'd0);
        is_space = 1'b0;
        valid    = 1'b1;
        case (char_code)
            6'd0:  sym = mk_sym(5'b00010, 3'd2);
            6'd1:  sym = mk_sym(5'b00001, 3'd4);
            6'd2:  sym = mk_sym(5'b00101, 3'd4);
            6'd3:  sym = mk_sym(5'b00001, 3'd3);
            6'd4:  sym = mk_sym(5'b00000, 3'd1);
            6'd5:  sym = mk_sym(5'b00100, 3'd4);
            6'd6:  sym = mk_sym(5'b00011, 3'd3);
            6'd7:  sym = mk_sym(5'b00000, 3'd4);
            6'd8:  sym = mk_sym(5'b00000, 3'd2);
            6'd9:  sym = mk_sym(5'b01110, 3'd4);
            6'd10: sym = mk_sym(5'b00101, 3'd3);
            6'd11: sym = mk_sym(5'b00010, 3'd4);
            6'd12: sym = mk_sym(5'b00011, 3'd2);
            6'd13: sym = mk_sym(5'b00001, 3'd2);
            6'd14: sym = mk_sym(5'b00111, 3'd3);
            6'd15: sym = mk_sym(5'b00110, 3'd4);
            6'd16: sym = mk_sym(5'b01011, 3'd4);
            6'd17: sym = mk_sym(5'b00010, 3'd3);
            6'd18: sym = mk_sym(5'b00000, 3'd3);
            6'd19: sym = mk_sym(5'b00001, 3'd1);
            6'd20: sym = mk_sym(5'b00100, 3'd3);
            6'd21: sym = mk_sym(5'b01000, 3'd4);
            6'd22: sym = mk_sym(5'b00110, 3'd3);
            6'd23: sym = mk_sym(5'b01001, 3'd4);
            6'd24: sym = mk_sym(5'b01101, 3'd4);
            6'd25: sym = mk_sym(5'b00011, 3'd4);
            // Digits: all five elements, dashes first for 6-9/0, dots first for 1-5.
            6'd26: sym = mk_sym(5'b11111, 3'd5);
            6'd27: sym = mk_sym(5'b11110, 3'd5);
            6'd28: sym = mk_sym(5'b11100, 3'd5);
            6'd29: sym = mk_sym(5'b11000, 3'd5);
            6'd30: sym = mk_sym(5'b10000, 3'd5);
            6'd31: sym = mk_sym(5'b00000, 3'd5);
            6'd32: sym = mk_sym(5'b00001, 3'd5);
            6'd33: sym = mk_sym(5'b00011, 3'd5);
            6'd34: sym = mk_sym(5'b00111, 3'd5);
            6'd35: sym = mk_sym(5'b01111, 3'd5);
            CH_SPACE: is_space = 1'b1;
            default:  valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one character per handshake and plays its dot/dash
// pattern on key_out with exact unit timing.
module morse_keyer #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 3,
    parameter int WORD_UNITS  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] char_code,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import morse_pkg::*;

    localparam int CYC_W     = $clog2(UNIT_CYCLES);
    localparam int MAX_UNITS = max3(DASH_UNITS, GAP_UNITS, WORD_UNITS);
    localparam int UNT_W     = $clog2(MAX_UNITS + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [UNT_W-1:0] UNT_ONE  = UNT_W'(1);
    localparam logic [UNT_W-1:0] DASH_U   = UNT_W'(DASH_UNITS);
    localparam logic [UNT_W-1:0] GAP_U    = UNT_W'(GAP_UNITS);
    localparam logic [UNT_W-1:0] WORD_U   = UNT_W'(WORD_UNITS);

    morse_sym_t rom_sym;
    logic       rom_space;
    logic       rom_valid;

    morse_rom u_rom (
        .char_code (char_code),
        .sym       (rom_sym),
        .is_space  (rom_space),
        .valid     (rom_valid)
    );

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [UNT_W-1:0]   unit_q, unit_d;
    logic [UNT_W-1:0]   target_q, target_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               key_q, key_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               unit_end;
    logic               state_end;

    always_comb begin
        unit_end  = (cyc_q == CYC_LAST);
        state_end = unit_end && (unit_q == target_q - UNT_ONE);

        state_d  = state_q;
        cyc_d    = unit_end ? '0 : cyc_q + CYC_ONE;
        unit_d   = unit_end ? unit_q + UNT_ONE : unit_q;
        target_d = target_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cyc_d  = '0;
                unit_d = '0;
                key_d  = 1'b0;
                if (char_valid) begin
                    if (rom_valid && !rom_space) begin
                        state_d  = ST_MARK;
                        key_d    = 1'b1;
                        pat_d    = rom_sym.pattern;
                        cnt_d    = rom_sym.len;
                        target_d = rom_sym.pattern[0] ? DASH_U : UNT_ONE;
                    end else if (rom_valid) begin
                        state_d  = ST_GAP;
                        target_d = WORD_U;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (state_end) begin
                    key_d = 1'b0;
                    if (cnt_q > 3'd1) begin
                        state_d  = ST_SPACE;
                        target_d = UNT_ONE;
                    end else begin
                        state_d  = ST_GAP;
                        target_d = GAP_U;
                    end
                end
            end
            ST_SPACE: begin
                // Advance to the next element as the inter-element space ends.
                if (state_end) begin
                    state_d  = ST_MARK;
                    key_d    = 1'b1;
                    pat_d    = {1'b0, pat_q[MAX_LEN-1:1]};
                    cnt_d    = cnt_q - 3'd1;
                    target_d = pat_q[1] ? DASH_U : UNT_ONE;
                end
            end
            ST_GAP: begin
                if (state_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                key_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                key_d   = 1'b0;
            end
        endcase

        // Every state entry restarts the unit timer so durations are exact.
        if (state_d != state_q) begin
            cyc_d  = '0;
            unit_d = '0;
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            unit_q   <= '0;
            target_q <= '0;
            pat_q    <= '0;
            cnt_q    <= '0;
            key_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            unit_q   <= unit_d;
            target_q <= target_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign key_out    = key_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign char_ready = ready_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with a 4-cycle unit: every character's
// waveform is checked cycle by cycle against its dot/dash text.
module tb_morse_keyer;

    localparam int UNIT = 4;
    localparam int DASH = 3 * UNIT;
    localparam int GAP  = 3 * UNIT;
    localparam int WORD = 7 * UNIT;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] char_code;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;

    int n_asserts = 0;
    int n_fail    = 0;

    string morse_txt [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    morse_keyer #(
        .UNIT_CYCLES (UNIT),
        .DASH_UNITS  (3),
        .GAP_UNITS   (3),
        .WORD_UNITS  (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_code  (char_code),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check key_out (and busy) for n cycles starting at the current falling edge.
    task automatic key_run(input logic val, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s key c%0d", tag, i), key_out, val);
            chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [5:0] code);
        char_code  = code;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic play(input int code);
        string s;
        s = morse_txt[code];
        send(6'(code));
        for (int i = 0; i < s.len(); i++) begin
            key_run(1'b1, (s[i] == "-") ? DASH : UNIT, $sformatf("ch%0d m%0d", code, i));
            if (i < s.len() - 1)
                key_run(1'b0, UNIT, $sformatf("ch%0d s%0d", code, i));
        end
        key_run(1'b0, GAP, $sformatf("ch%0d gap", code));
        chk($sformatf("ch%0d done", code), done, 1'b1);
        chk($sformatf("ch%0d ready", code), char_ready, 1'b1);
        chk($sformatf("ch%0d key idle", code), key_out, 1'b0);
        @(negedge clk);
        chk($sformatf("ch%0d done clr", code), done, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_code  = 6'd0;
        #2;
        chk("rst key", key_out, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst ready", char_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Every letter and digit, beginning with 'A' and ending with '9'.
        for (int c = 0; c < 36; c++) play(c);

        // 'E' then 'T' with valid held: T must wait for the done cycle.
        char_code  = 6'd4;
        char_valid = 1'b1;
        @(negedge clk);
        char_code = 6'd19;
        key_run(1'b1, UNIT, "E");
        key_run(1'b0, GAP, "E gap");
        chk("ET done", done, 1'b1);
        chk("ET ready", char_ready, 1'b1);
        chk("ET key", key_out, 1'b0);
        @(negedge clk);
        char_valid = 1'b0;
        key_run(1'b1, DASH, "T");
        key_run(1'b0, GAP, "T gap");
        chk("T done", done, 1'b1);
        @(negedge clk);

        // Word space: silent and busy for seven units.
        send(6'd36);
        key_run(1'b0, WORD, "word");
        chk("word done", done, 1'b1);
        chk("word busy", busy, 1'b0);
        @(negedge clk);

        // Invalid code: one-cycle err, no mark, no done.
        send(6'd40);
        chk("inv err", err, 1'b1);
        chk("inv ready", char_ready, 1'b0);
        chk("inv key", key_out, 1'b0);
        chk("inv busy", busy, 1'b1);
        @(negedge clk);
        chk("inv err clr", err, 1'b0);
        chk("inv ready back", char_ready, 1'b1);
        chk("inv no done", done, 1'b0);
        chk("inv key idle", key_out, 1'b0);

        // Asynchronous reset in the middle of T's dash.
        send(6'd19);
        key_run(1'b1, 5, "T pre-rst");
        #2;
        reset = 1'b1;
        #1;
        chk("arst key", key_out, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst done", done, 1'b0);
        chk("arst err", err, 1'b0);
        chk("arst ready", char_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst key", key_out, 1'b0);
        chk("post-rst ready", char_ready, 1'b1);
        send(6'd4);
        key_run(1'b1, UNIT, "E post-rst");
        key_run(1'b0, GAP, "E post-rst gap");
        chk("E post-rst done", done, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
